sd_seq_generator: RTL and testbench
===================================

Name: sd_seq_generator

Overview:
- Serial pattern transmitter: the stimulus-side counterpart of the Moore sequence detector.
- Accepts a parallel pattern word through a valid/ready handshake and drives it MSB-first, one bit per clock, on a single serial line.
- Optional repeat count; a configurable idle gap separates repetitions.
- Drives the detector's sequence_in in block-level and system-level integration.

Parameters:
- PATTERN_W, 4, pattern length in bits (min 1).
- CNT_W, 4, width of the repeat-count input.
- GAP_CYCLES, 2, idle-level cycles inserted between repetitions (0 = back-to-back).
- IDLE_LEVEL, 0, level driven on sequence_out when not emitting pattern bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pattern_in  input  PATTERN_W  pattern to transmit; bit PATTERN_W-1 is sent first.
- repeat_in  input  CNT_W  extra repetitions; total frames = repeat_in+1.
- start_valid  input  1  request to start a transmission.
- start_ready  output  1  block can accept a request.
- abort  input  1  synchronous cancel of the current transmission.
- sequence_out  output  1  serial bit stream, registered.
- busy  output  1  high while not in IDLE.
- frame_done  output  1  single-cycle pulse at completion of the final repetition.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state = IDLE
  - sequence_out = IDLE_LEVEL, busy = 0, frame_done = 0
  - shift register and counters = 0
- start_ready = (state==IDLE) & ~abort, combinational. Handshakes while reset is high are ignored.
- States:
  - IDLE:
    - Drives IDLE_LEVEL.
    - On start_valid & start_ready: latch pattern_in into the shift register, latch repeat_in into rep_cnt, set bit_cnt = PATTERN_W-1, go to SHIFT.
  - SHIFT:
    - sequence_out = current MSB of the shift register. The first bit appears in the cycle after the accepting edge (latency 1).
    - Shift left each cycle and decrement bit_cnt.
    - When bit_cnt==0:
      - rep_cnt==0 -> DONE.
      - rep_cnt!=0 and GAP_CYCLES>0 -> GAP.
      - rep_cnt!=0 and GAP_CYCLES==0 -> reload the latched pattern copy, decrement rep_cnt, stay in SHIFT.
  - GAP:
    - Drives IDLE_LEVEL for exactly GAP_CYCLES cycles via gap_cnt.
    - Then reload the pattern, decrement rep_cnt, go to SHIFT.
  - DONE:
    - One cycle only: frame_done = 1, sequence_out = IDLE_LEVEL, busy = 1.
    - Next state IDLE.
- Pattern bits must be re-emitted identically on every repetition. Keep a separate latched copy so pattern_in may change after acceptance.
- Total busy cycles = (repeat_in+1)*PATTERN_W + repeat_in*GAP_CYCLES + 1.
- abort:
  - Sampled at every rising edge.
  - In any non-IDLE state, forces IDLE on the next edge with sequence_out = IDLE_LEVEL and no frame_done.
  - abort in IDLE has no effect other than deasserting start_ready. abort together with start_valid in IDLE means no acceptance.
- Back-to-back transmissions: start_ready is high in the cycle after DONE, so a new request is accepted then. Minimum one IDLE_LEVEL cycle between transmissions.
- Counter widths:
  - bit_cnt: $clog2(PATTERN_W), min 1.
  - gap_cnt: $clog2(GAP_CYCLES+1), min 1.
  - rep_cnt: CNT_W. repeat_in = all-ones gives 2^CNT_W frames; no wrap.
- Asynchronous reset mid-transmission:
  - Output returns to IDLE_LEVEL immediately.
  - On release, the block sits in IDLE; no partial frame resumes.

Decomposition:
- Package sd_fsm_pkg:
  - State enum: IDLE, SHIFT, GAP, DONE.
  - Default IDLE_LEVEL constant.
  - Shared with the Moore detector, which uses the same package for its state type.
- Optional sub-module sd_piso_shift: parallel-in serial-out register with load, shift and reload-from-copy. The FSM and counters stay in the top module.

Test Plan:
- Reset, then pattern_in=4'b1011, repeat_in=0, one start pulse:
  - sequence_out = 1,0,1,1 in the 4 cycles after acceptance.
  - frame_done pulses in the 5th cycle.
  - busy is high for 5 cycles.
  - Loopback to the Moore detector: detector_out asserts once.
- pattern 4'b1011, repeat_in=2, GAP_CYCLES=2:
  - Stream is 1011 00 1011 00 1011.
  - busy is high for 17 cycles; one frame_done pulse.
  - Detector asserts 3 times.
- GAP_CYCLES=0 build, pattern 4'b1011, repeat_in=1:
  - Stream is 10111011 with no gap.
  - frame_done in cycle 9.
  - Overlapping detection in the detector behaves per its own spec.
- abort asserted on the 2nd bit of pattern 4'b1111, repeat_in=3:
  - sequence_out returns to 0 on the next edge; busy drops; no frame_done.
  - start_ready rises once abort deasserts.
- Async reset pulse in the middle of the GAP state:
  - sequence_out = 0 and busy = 0 immediately, without waiting for a clock edge.
  - After release, a new start with pattern 4'b0110 transmits 0,1,1,0 correctly.
- start_valid held high continuously with pattern 4'b1001:
  - Accepted only when start_ready is high.
  - Back-to-back transmissions separated by exactly one idle cycle.
  - pattern_in changed mid-frame does not corrupt the frame in progress.

Source files
------------

// File: rtl/sd_fsm_pkg.sv
// Shared state type and constants for the serial sequence generator and detector.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sd_fsm_pkg;

    // Common FSM state encoding; the Moore detector reuses this type.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } sd_state_e;

    // Level held on the serial line whenever no pattern bit is being driven.
    localparam logic SD_IDLE_LEVEL = 1'b0;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int sd_cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sd_piso_shift.sv
// Parallel-in serial-out register with a latched pattern copy for repetitions.
// Latency: bit_o is combinational; it is the bit the caller should register this edge.
// Backpressure: none; the caller sequences load/shift/reload.
module sd_piso_shift #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         reload_i,
    input  logic [W-1:0] pattern_i,
    output logic         bit_o
);

    // data_q holds the bits still to be emitted, MSB next; the emitted bit
    // itself lives in the caller's output flop, so loads pre-shift by one.
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] copy_q, copy_d;

    // Select the next serial bit and the next contents of both registers.
    always_comb begin
        data_d = data_q;
        copy_d = copy_q;
        bit_o  = data_q[W-1];
        if (load_i) begin
            copy_d = pattern_i;
            data_d = pattern_i << 1;
            bit_o  = pattern_i[W-1];
        end else if (reload_i) begin
            data_d = copy_q << 1;
            bit_o  = copy_q[W-1];
        end else if (shift_i) begin
            data_d = data_q << 1;
        end
    end

    // Shift and copy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            copy_q <= '0;
        end else begin
            data_q <= data_d;
            copy_q <= copy_d;
        end
    end

endmodule

// File: rtl/sd_seq_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with idle gaps.
// Latency: first bit on sequence_out in the cycle after the accepting edge.
// Backpressure: start_ready is low whenever a transmission is in progress or abort is high.
module sd_seq_generator
    import sd_fsm_pkg::*;
#(
    parameter int   PATTERN_W  = 4,
    parameter int   CNT_W      = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = SD_IDLE_LEVEL
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [CNT_W-1:0]     repeat_in,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 abort,
    output logic                 sequence_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BIT_W = sd_cnt_width(PATTERN_W);
    localparam int GAP_W = sd_cnt_width(GAP_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PATTERN_W - 1);
    // Gap counter counts down to zero, so a GAP_CYCLES-long gap starts at GAP_CYCLES-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    sd_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             seq_q, seq_d;

    logic load, shift, reload, emit;
    logic piso_bit;

    assign start_ready  = (state_q == IDLE) & ~abort;
    assign busy         = (state_q != IDLE);
    assign frame_done   = (state_q == DONE);
    assign sequence_out = seq_q;

    sd_piso_shift #(
        .W (PATTERN_W)
    ) u_piso (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (load),
        .shift_i   (shift),
        .reload_i  (reload),
        .pattern_i (pattern_in),
        .bit_o     (piso_bit)
    );

    // Next-state, counter and shift-control logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        load      = 1'b0;
        shift     = 1'b0;
        reload    = 1'b0;
        emit      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    load      = 1'b1;
                    emit      = 1'b1;
                    rep_cnt_d = repeat_in;
                    bit_cnt_d = BIT_LAST;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != '0) begin
                    shift     = 1'b1;
                    emit      = 1'b1;
                    bit_cnt_d = bit_cnt_q - BIT_W'(1);
                end else if (rep_cnt_q == '0) begin
                    state_d = DONE;
                end else if (GAP_CYCLES > 0) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP;
                end else begin
                    reload    = 1'b1;
                    emit      = 1'b1;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    bit_cnt_d = BIT_LAST;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    reload    = 1'b1;
                    emit      = 1'b1;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    bit_cnt_d = BIT_LAST;
                    state_d   = SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            load    = 1'b0;
            shift   = 1'b0;
            reload  = 1'b0;
            emit    = 1'b0;
        end

        seq_d = emit ? piso_bit : IDLE_LEVEL;
    end

    // State, counters and the registered serial output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            seq_q     <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            seq_q     <= seq_d;
        end
    end

endmodule

// File: tb/tb_sd_seq_generator.sv
// Bench for sd_seq_generator: scoreboard of expected per-cycle outputs for two builds.
// Latency: expected stream starts the cycle after each modelled acceptance.
// Backpressure: acceptance is predicted from the model's own idle state and abort.
module tb_sd_seq_generator;

    typedef struct packed {
        logic seq;
        logic busy;
        logic done;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pattern_in = '0;
    logic [3:0] repeat_in  = '0;
    logic       start_valid = 1'b0;
    logic       abort = 1'b0;
    logic       start_ready, sequence_out, busy, frame_done;

    logic       start_valid0 = 1'b0;
    logic       abort0 = 1'b0;
    logic       start_ready0, sequence_out0, busy0, frame_done0;

    int total = 0;
    int bad   = 0;

    exp_t q1[$];
    exp_t q0[$];

    always #5 clock = ~clock;

    sd_seq_generator #(
        .PATTERN_W (4), .CNT_W (4), .GAP_CYCLES (2), .IDLE_LEVEL (1'b0)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .pattern_in   (pattern_in),
        .repeat_in    (repeat_in),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .abort        (abort),
        .sequence_out (sequence_out),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    sd_seq_generator #(
        .PATTERN_W (4), .CNT_W (4), .GAP_CYCLES (0), .IDLE_LEVEL (1'b0)
    ) u_dut_nogap (
        .clock        (clock),
        .reset        (reset),
        .pattern_in   (pattern_in),
        .repeat_in    (repeat_in),
        .start_valid  (start_valid0),
        .start_ready  (start_ready0),
        .abort        (abort0),
        .sequence_out (sequence_out0),
        .busy         (busy0),
        .frame_done   (frame_done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle outputs of one whole transmission.
    task automatic push_stream(input int sel, input logic [3:0] pat, input int rep);
        int   gap;
        exp_t e;
        gap = (sel == 1) ? 2 : 0;
        for (int r = 0; r <= rep; r++) begin
            for (int i = 3; i >= 0; i--) begin
                e = '{seq: pat[i], busy: 1'b1, done: 1'b0};
                if (sel == 1) q1.push_back(e); else q0.push_back(e);
            end
            if (r < rep) begin
                for (int g = 0; g < gap; g++) begin
                    e = '{seq: 1'b0, busy: 1'b1, done: 1'b0};
                    if (sel == 1) q1.push_back(e); else q0.push_back(e);
                end
            end
        end
        e = '{seq: 1'b0, busy: 1'b1, done: 1'b1};
        if (sel == 1) q1.push_back(e); else q0.push_back(e);
    endtask

    exp_t e1, e0;
    logic idle1, idle0;

    // Compare both DUTs every cycle against the scoreboard and predict acceptances.
    always @(negedge clock) begin
        if (q1.size() > 0) begin e1 = q1.pop_front(); idle1 = 1'b0; end
        else begin e1 = '0; idle1 = 1'b1; end
        check("seq",   sequence_out, e1.seq);
        check("busy",  busy,         e1.busy);
        check("done",  frame_done,   e1.done);
        check("ready", start_ready,  idle1 & ~abort);

        if (q0.size() > 0) begin e0 = q0.pop_front(); idle0 = 1'b0; end
        else begin e0 = '0; idle0 = 1'b1; end
        check("seq0",   sequence_out0, e0.seq);
        check("busy0",  busy0,         e0.busy);
        check("done0",  frame_done0,   e0.done);
        check("ready0", start_ready0,  idle0 & ~abort0);

        if (!reset) begin
            if (idle1 && start_valid && !abort) push_stream(1, pattern_in, int'(repeat_in));
            else if (!idle1 && abort) q1.delete();
            if (idle0 && start_valid0 && !abort0) push_stream(0, pattern_in, int'(repeat_in));
            else if (!idle0 && abort0) q0.delete();
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < budget) begin
            @(posedge clock);
            n++;
        end
        if (n >= budget) begin
            check("timeout_q1", q1.size(), 0);
            check("timeout_q0", q0.size(), 0);
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic start_pulse(input logic [3:0] pat, input logic [3:0] rep);
        pattern_in  = pat;
        repeat_in   = rep;
        start_valid = 1'b1;
        @(posedge clock); #1;
        start_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_seq",  sequence_out, 0);
        check("rst_busy", busy,         0);
        check("rst_done", frame_done,   0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // Single frame, then three frames with gaps.
        start_pulse(4'b1011, 4'd0);
        wait_idle(50);
        start_pulse(4'b1011, 4'd2);
        wait_idle(50);

        // Back-to-back repetitions on the gapless build.
        pattern_in   = 4'b1011;
        repeat_in    = 4'd1;
        start_valid0 = 1'b1;
        @(posedge clock); #1;
        start_valid0 = 1'b0;
        wait_idle(50);

        // Abort on the second bit, then abort together with a request in IDLE.
        start_pulse(4'b1111, 4'd3);
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(posedge clock); #1;
        abort = 1'b1;
        start_valid = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        start_valid = 1'b0;
        wait_idle(50);

        // Asynchronous reset in the first gap cycle, then a fresh frame.
        start_pulse(4'b1011, 4'd1);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("arst_seq",  sequence_out, 0);
        check("arst_busy", busy,         0);
        check("arst_done", frame_done,   0);
        q1.delete();
        @(posedge clock); #2;
        reset = 1'b0;
        @(posedge clock); #1;
        start_pulse(4'b0110, 4'd0);
        wait_idle(50);

        // Request held high continuously; pattern changes while a frame is in flight.
        pattern_in  = 4'b1001;
        repeat_in   = 4'd0;
        start_valid = 1'b1;
        repeat (3) @(posedge clock);
        #1 pattern_in = 4'b0110;
        repeat (9) @(posedge clock);
        #1 start_valid = 1'b0;
        wait_idle(50);

        // Maximum repeat count: 16 frames, no wrap.
        start_pulse(4'b1100, 4'hF);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
